dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the multicycle core's load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake and sequences the synchronous data RAM with a configurable read latency.
- Returns read data or an error flag as a one-cycle response pulse.
- Misaligned and out-of-range accesses are filtered before they reach the RAM.

Parameters:
- ADDR_W, 9, RAM byte-address width; legal range 0 .. 2^ADDR_W-1.
- DATA_W, 32, data word width.
- RD_LAT, 1, RAM read latency in cycles from address presented to ram_dout valid; legal 1..3.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present; held stable by requester until accepted.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  DATA_W  store data.
- req_ready  output  1  controller can accept a request this cycle.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  load data; valid with rsp_valid.
- rsp_err  output  1  access faulted; valid with rsp_valid.
- ram_we  output  1  RAM write strobe.
- ram_addr  output  ADDR_W  RAM byte address.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM read data.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, req_ready = 1.
  - rsp_valid, rsp_err, ram_we = 0.
  - rsp_rdata, ram_addr, ram_din = 0.
  - Internal latch and wait counter = 0.
- Reset mid-operation aborts the access. An in-flight store may or may not have committed. No response is produced.
- FSM states: IDLE, CHECK, WR, RD_WAIT, RSP.
- req_ready = 1 only in IDLE. Accept = req_valid && req_ready.
- On accept, latch req_we, req_addr and req_wdata, then go to CHECK. A request arriving while busy is not accepted; the requester holds it.
- CHECK (1 cycle):
  - Fault if req_addr[1:0] != 0, or if any bit of req_addr[31:ADDR_W] is nonzero.
  - On fault, go to RSP with err = 1. The RAM is never accessed.
  - Otherwise a store goes to WR and a load goes to RD_WAIT.
- WR (1 cycle):
  - ram_we = 1, ram_addr = latched addr[ADDR_W-1:0], ram_din = latched wdata.
  - Next state RSP with err = 0 and rdata = 0.
- RD_WAIT:
  - ram_addr is held and ram_we = 0.
  - A counter counts RD_LAT cycles. On the last cycle, ram_dout is captured into the response data register, then the FSM goes to RSP.
- RSP (1 cycle):
  - rsp_valid = 1, with rsp_rdata and rsp_err as registered.
  - Next state IDLE. There is no response back-pressure; the requester must sample on the pulse.
- rsp_rdata holds its last value outside RSP. rsp_err is 0 outside RSP.
- Latency from accept edge to rsp_valid:
  - Store: 3 cycles.
  - Load: 2 + RD_LAT cycles.
  - Fault: 2 cycles.
- Throughput: a new accept is possible the cycle after RSP.
- ram_we is never high outside WR. ram_addr keeps its last value while IDLE.

Optional Feature:
- Macro: DMEM_CTRL_CYCLE_CNT_EN.
- With the macro defined:
  - A 32-bit free-running cycle counter increments every clk, resets to 0 and wraps 0xFFFFFFFF -> 0.
  - Word address 2^ADDR_W-4 (0x1FC by default) maps to the counter.
  - A load there bypasses the RAM: CHECK goes directly to RSP, rdata = the counter value sampled in CHECK, load latency 2.
  - A store there clears the counter to 0 with no RAM write, latency 3.
- Without the macro: 0x1FC is ordinary RAM, and the counter logic is absent.

Test Plan:
- Reset: hold rst low with req_valid = 1 -> req_ready = 1, rsp_valid = 0, ram_we = 0. After release the request is accepted on the first edge.
- Store then load: store 0xDEADBEEF to 0x010, then load 0x010 with RD_LAT = 1 -> ram_we is high exactly 1 cycle, rsp at +3, and the load rsp at +3 returns 0xDEADBEEF with err = 0.
- Read latency: RD_LAT = 3, load 0x020 holding 0x12345678 -> rsp_valid exactly 5 cycles after accept with the correct data.
- Faults:
  - Store to 0x013 -> rsp_err = 1 at +2 and ram_we never high.
  - Load from 0x00000200 -> rsp_err = 1 and rdata = 0.
- Back-to-back: req_valid held with a new address during a busy load -> req_ready = 0 until RSP completes; the second request is accepted the cycle after RSP and its data is not corrupted.
- DMEM_CTRL_CYCLE_CNT_EN:
  - Store any value to 0x1FC, then load 0x1FC 10 cycles later -> returned value equals the cycles elapsed (store CHECK to load CHECK).
  - Same test without the macro -> the RAM data previously written is returned.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store at a time, sequences the data RAM, returns a one-cycle response.
// Optional DMEM_CTRL_CYCLE_CNT_EN maps a free-running 32-bit cycle counter at word address 2^ADDR_W-4.
module dmem_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // state   | meaning
    // IDLE    | ready for a new request
    // CHECK   | alignment / range check of the latched address
    // WR      | RAM write strobe asserted
    // RD_WAIT | waiting RD_LAT cycles for ram_dout
    // RSP     | one-cycle response pulse
    typedef enum logic [2:0] {IDLE, CHECK, WR, RD_WAIT, RSP} stateT;

    stateT             state;
    logic              latWe;
    logic [31:0]       latAddr;
    logic [DATA_W-1:0] latWdata;
    logic [1:0]        waitCnt;
    logic              fault;
    logic              cntHit;
    logic [DATA_W-1:0] cntVal;

    assign fault = (latAddr[1:0] != 2'b00) || (|latAddr[31:ADDR_W]);

`ifdef DMEM_CTRL_CYCLE_CNT_EN
    logic [31:0] cycCnt;

    assign cntHit = (latAddr[ADDR_W-1:0] == ADDR_W'((1 << ADDR_W) - 4));
    assign cntVal = DATA_W'(cycCnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycCnt <= '0;
        end else if (state == CHECK && !fault && cntHit && latWe) begin
            cycCnt <= '0;
        end else begin
            cycCnt <= cycCnt + 32'd1;
        end
    end
`else
    assign cntHit = 1'b0;
    assign cntVal = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            latWe     <= 1'b0;
            latAddr   <= '0;
            latWdata  <= '0;
            waitCnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            ram_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        latWe     <= req_we;
                        latAddr   <= req_addr;
                        latWdata  <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (fault) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RSP;
                    end else if (cntHit) begin
                        // counter access never touches the RAM; a store just passes through WR
                        if (latWe) begin
                            state <= WR;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= cntVal;
                            state     <= RSP;
                        end
                    end else if (latWe) begin
                        ram_we   <= 1'b1;
                        ram_addr <= latAddr[ADDR_W-1:0];
                        ram_din  <= latWdata;
                        state    <= WR;
                    end else begin
                        ram_addr <= latAddr[ADDR_W-1:0];
                        waitCnt  <= 2'(RD_LAT - 1);
                        state    <= RD_WAIT;
                    end
                end
                WR: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                    state     <= RSP;
                end
                RD_WAIT: begin
                    if (waitCnt == 2'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ram_dout;
                        state     <= RSP;
                    end else begin
                        waitCnt <= waitCnt - 2'd1;
                    end
                end
                RSP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: two lanes (RD_LAT 1 and 3), each with its own RAM model,
// directed plus random stimulus, and a monitor comparing every cycle against a reference model.
module tb_dmem_ctrl;

`ifdef DMEM_CTRL_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rspT;

    typedef struct {
        int          cyc;
        logic [8:0]  addr;
        logic [31:0] data;
    } wrT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    bit   done [2];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        req_valid = 1'b0;
        logic        req_we = 1'b0;
        logic [31:0] req_addr = '0;
        logic [31:0] req_wdata = '0;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_rdata;
        logic        rsp_err;
        logic        ram_we;
        logic [8:0]  ram_addr;
        logic [31:0] ram_din;
        logic [31:0] ram_dout;

        dmem_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_LAT(LAT)) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .req_ready (req_ready),
            .rsp_valid (rsp_valid),
            .rsp_rdata (rsp_rdata),
            .rsp_err   (rsp_err),
            .ram_we    (ram_we),
            .ram_addr  (ram_addr),
            .ram_din   (ram_din),
            .ram_dout  (ram_dout)
        );

        // RAM model: data for an address is valid LAT cycles after it is presented
        logic [31:0] mem [128];
        logic [31:0] rd0, dl0, dl1;
        assign rd0 = mem[ram_addr[8:2]];
        assign ram_dout = (LAT == 1) ? rd0 : (LAT == 2) ? dl0 : dl1;

        always @(posedge clk) begin
            if (rst !== 1'b1) begin
                for (int i = 0; i < 128; i++) mem[i] <= '0;
            end else if (ram_we) begin
                mem[ram_addr[8:2]] <= ram_din;
            end
            dl0 <= rd0;
            dl1 <= dl0;
        end

        // reference model state
        logic [31:0] refMem [128];
        rspT rq[$];
        wrT  wq[$];
        int  busyStart = 1;
        int  busyEnd = 0;
        bit  haveRsp = 1'b0;
        int  clearEdge = 0;
        logic [31:0] lastRdata = '0;

        task automatic gap(input int n);
            repeat (n) begin
                @(posedge clk);
                #2;
            end
        endtask

        task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
            int waited;
            int acc;
            int lat;
            logic [31:0] d;
            logic e;
            bit isFault;
            bit isCnt;
            waited = 0;
            req_valid = 1'b1;
            req_we = we;
            req_addr = addr;
            req_wdata = wd;
            while (!req_ready && waited < 60) begin
                @(posedge clk);
                #2;
                waited++;
            end
            check($sformatf("lane%0d accept within bound", g), req_ready, 1);
            if (!req_ready) begin
                req_valid = 1'b0;
                return;
            end
            acc = cyc + 1;
            if (waited > 0 && haveRsp)
                check($sformatf("lane%0d accept cycle after RSP", g), acc, busyEnd + 2);
            isFault = (addr % 4 != 0) || (addr >= 512);
            isCnt = CNT_EN && (addr == 508);
            d = '0;
            e = 1'b0;
            if (isFault) begin
                lat = 2;
                e = 1'b1;
            end else if (we) begin
                lat = 3;
                if (isCnt) begin
                    clearEdge = acc + 1;
                end else begin
                    refMem[addr / 4] = wd;
                    wq.push_back('{cyc: acc + 1, addr: addr[8:0], data: wd});
                end
            end else if (isCnt) begin
                lat = 2;
                d = 32'(acc - clearEdge);
            end else begin
                lat = 2 + LAT;
                d = refMem[addr / 4];
            end
            rq.push_back('{cyc: acc + lat - 1, data: d, err: e});
            busyStart = acc;
            busyEnd = acc + lat - 1;
            haveRsp = 1'b1;
            @(posedge clk);
            #2;
            req_valid = 1'b0;
        endtask

        initial begin : stim
            for (int i = 0; i < 128; i++) refMem[i] = '0;
            req_valid = 1'b1;
            req_we = 1'b1;
            req_addr = 32'h10;
            req_wdata = 32'hDEADBEEF;
            repeat (2) @(posedge clk);
            #2;
            check($sformatf("lane%0d reset req_ready", g), req_ready, 1);
            check($sformatf("lane%0d reset rsp_valid", g), rsp_valid, 0);
            check($sformatf("lane%0d reset rsp_err", g), rsp_err, 0);
            check($sformatf("lane%0d reset ram_we", g), ram_we, 0);
            check($sformatf("lane%0d reset rsp_rdata", g), rsp_rdata, 0);
            check($sformatf("lane%0d reset ram_addr", g), ram_addr, 0);
            check($sformatf("lane%0d reset ram_din", g), ram_din, 0);
            wait (rst === 1'b1);
            issue(1'b1, 32'h010, 32'hDEADBEEF);
            gap(2);
            issue(1'b0, 32'h010, 32'h0);
            gap(1);
            issue(1'b1, 32'h020, 32'h12345678);
            issue(1'b0, 32'h020, 32'h0);
            issue(1'b1, 32'h013, 32'hCAFEF00D);
            issue(1'b0, 32'h00000200, 32'h0);
            issue(1'b0, 32'h010, 32'h0);
            issue(1'b0, 32'h020, 32'h0);
            issue(1'b1, 32'h1FC, 32'h55AA55AA);
            gap(10);
            issue(1'b0, 32'h1FC, 32'h0);
            for (int n = 0; n < 40; n++) begin
                int sel;
                logic [31:0] a;
                sel = $urandom_range(0, 5);
                if (sel <= 2) a = 32'($urandom_range(0, 15) * 4);
                else if (sel == 3) a = 32'($urandom_range(0, 126) * 4 + $urandom_range(1, 3));
                else a = $urandom | (32'h1 << $urandom_range(9, 31));
                issue(1'($urandom_range(0, 1)), a, $urandom);
                if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
            end
            for (int i = 0; i < 100 && (rq.size() > 0 || wq.size() > 0); i++) @(posedge clk);
            check($sformatf("lane%0d all responses drained", g), rq.size() + wq.size(), 0);
            done[g] = 1'b1;
        end

        initial begin : mon
            rspT r;
            wrT  w;
            forever begin
                @(negedge clk);
                if (rst !== 1'b1) continue;
                check($sformatf("lane%0d req_ready", g), req_ready, !(cyc >= busyStart && cyc <= busyEnd));
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    w = wq.pop_front();
                    check($sformatf("lane%0d ram_we in WR", g), ram_we, 1);
                    check($sformatf("lane%0d ram_addr", g), ram_addr, w.addr);
                    check($sformatf("lane%0d ram_din", g), ram_din, w.data);
                end else begin
                    check($sformatf("lane%0d ram_we idle", g), ram_we, 0);
                end
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    r = rq.pop_front();
                    check($sformatf("lane%0d rsp_valid on time", g), rsp_valid, 1);
                    check($sformatf("lane%0d rsp_rdata", g), rsp_rdata, r.data);
                    check($sformatf("lane%0d rsp_err", g), rsp_err, r.err);
                    lastRdata = r.data;
                end else begin
                    check($sformatf("lane%0d rsp_valid idle", g), rsp_valid, 0);
                    check($sformatf("lane%0d rsp_err idle", g), rsp_err, 0);
                    check($sformatf("lane%0d rsp_rdata held", g), rsp_rdata, lastRdata);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 20000 && !(done[0] && done[1]); i++) @(posedge clk);
        check("both lanes completed", {done[1], done[0]}, 2'b11);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
